// File: rtl/decode_issue_stage_pkg.sv
// Shared types and SPU instruction decode helpers for the decode/issue stage.
// Instructions are held as [31:0], so SPU bit k is Verilog bit 31-k.
package decode_issue_stage_pkg;

   typedef enum logic [1:0] {PIPE_NONE, PIPE_EVEN, PIPE_ODD} pipe_t;
   typedef enum logic [2:0] {FMT_NONE, FMT_RR, FMT_RRR, FMT_RI7, FMT_RI10, FMT_RI16, FMT_RI18} fmt_t;
   typedef enum logic {ST_PAIR, ST_HOLD} state_t;

   localparam logic [10:0] OPC_LNOP = 11'b00000000001;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc;
   } issue_slot_t;

   typedef struct packed {
      pipe_t pipe;
      fmt_t  fmt;
      logic  wr_rt;
      logic  rd_rt;
   } op_info_t;

   typedef struct packed {
      logic       valid;
      logic [6:0] rnum;
   } dst_t;

   // Source slots: 0 = ra, 1 = rb, 2 = rc (RRR) or rt (stores/branches reading rt).
   typedef struct packed {
      logic [2:0]      valid;
      logic [2:0][6:0] rnum;
   } src_t;

   // Unrecognised opcodes go to the even pipe with no register side effects.
   function automatic op_info_t op_info(input logic [31:0] inst);
      op_info_t info;
      info = '{PIPE_EVEN, FMT_NONE, 1'b0, 1'b0};
      casez (inst[31:21])
         11'b1011???????: info = '{PIPE_ODD,  FMT_RRR,  1'b1, 1'b0};
         11'b1110???????: info = '{PIPE_EVEN, FMT_RRR,  1'b1, 1'b0};
         11'b0100001????: info = '{PIPE_EVEN, FMT_RI18, 1'b1, 1'b0};
         11'b00011100???: info = '{PIPE_EVEN, FMT_RI10, 1'b1, 1'b0};
         11'b00110100???: info = '{PIPE_ODD,  FMT_RI10, 1'b1, 1'b0};
         11'b00100100???: info = '{PIPE_ODD,  FMT_RI10, 1'b0, 1'b1};
         11'b001100110??: info = '{PIPE_ODD,  FMT_RI16, 1'b1, 1'b0};
         11'b001100100??: info = '{PIPE_ODD,  FMT_RI16, 1'b0, 1'b0};
         11'b010000001??: info = '{PIPE_EVEN, FMT_RI16, 1'b1, 1'b0};
         11'b00011000000: info = '{PIPE_EVEN, FMT_RR,   1'b1, 1'b0};
         11'b01011000100: info = '{PIPE_EVEN, FMT_RR,   1'b1, 1'b0};
         11'b01001000001: info = '{PIPE_EVEN, FMT_RR,   1'b1, 1'b0};
         11'b00111011100: info = '{PIPE_ODD,  FMT_RR,   1'b1, 1'b0};
         11'b00111000100: info = '{PIPE_ODD,  FMT_RR,   1'b1, 1'b0};
         11'b00001111000: info = '{PIPE_EVEN, FMT_RI7,  1'b1, 1'b0};
         11'b01000000001: info = '{PIPE_EVEN, FMT_NONE, 1'b0, 1'b0};
         OPC_LNOP:        info = '{PIPE_NONE, FMT_NONE, 1'b0, 1'b0};
         default: ;
      endcase
      return info;
   endfunction

   function automatic pipe_t pipe_of(input logic [31:0] inst);
      op_info_t info;
      info = op_info(inst);
      return info.pipe;
   endfunction

   function automatic dst_t dst_reg(input logic [31:0] inst);
      op_info_t info;
      dst_t     d;
      info   = op_info(inst);
      d.valid = info.wr_rt;
      d.rnum  = (info.fmt == FMT_RRR) ? inst[27:21] : inst[6:0];
      return d;
   endfunction

   function automatic src_t src_regs(input logic [31:0] inst);
      op_info_t info;
      src_t     s;
      info      = op_info(inst);
      s.rnum[0] = inst[13:7];
      s.rnum[1] = inst[20:14];
      s.rnum[2] = inst[6:0];
      case (info.fmt)
         FMT_RR:   s.valid = 3'b011;
         FMT_RRR:  s.valid = 3'b111;
         FMT_RI7:  s.valid = 3'b001;
         FMT_RI10: s.valid = {info.rd_rt, 2'b01};
         FMT_RI16: s.valid = {info.rd_rt, 2'b00};
         default:  s.valid = 3'b000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/decode_issue_stage_pair_hazard_check.sv
// Combinational pipe classification and intra-pair RAW detection for a fetched pair.
module pair_hazard_check
   import decode_issue_stage_pkg::*;
(
   input  logic [31:0] first_inst,
   input  logic [31:0] second_inst,
   output pipe_t       first_pipe,
   output pipe_t       second_pipe,
   output logic        same_pipe,
   output logic        raw
);

   dst_t first_dst;
   src_t second_src;

   assign first_pipe  = pipe_of(first_inst);
   assign second_pipe = pipe_of(second_inst);
   assign first_dst   = dst_reg(first_inst);
   assign second_src  = src_regs(second_inst);

   // LNOP never occupies a pipe, so two fillers do not count as a conflict.
   assign same_pipe = (first_pipe != PIPE_NONE) && (first_pipe == second_pipe);

   always_comb begin
      raw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (first_dst.valid && second_src.valid[i] && (second_src.rnum[i] == first_dst.rnum))
            raw = 1'b1;
      end
   end

endmodule

// File: rtl/decode_issue_stage.sv
// Steers a fetched instruction pair into the even/odd issue slots, splitting it over
// two cycles on a pipe conflict or intra-pair RAW hazard.
module decode_issue_stage
   import decode_issue_stage_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] first_inst,
   input  logic [31:0] second_inst,
   input  logic [31:0] pc_in,
   input  logic        flush,
   input  logic        ex_stall,
   output logic        stall_fetch,
   output logic        even_valid,
   output logic [31:0] even_inst,
   output logic [31:0] even_pc,
   output logic        odd_valid,
   output logic [31:0] odd_inst,
   output logic [31:0] odd_pc
);

   state_t      state, state_nxt;
   issue_slot_t buffer, buffer_nxt;
   issue_slot_t even_slot, even_nxt;
   issue_slot_t odd_slot, odd_nxt;
   issue_slot_t first_slot, second_slot;
   pipe_t       first_pipe, second_pipe, buffer_pipe;
   logic        same_pipe, raw;

   pair_hazard_check u_hazard (
      .first_inst  (first_inst),
      .second_inst (second_inst),
      .first_pipe  (first_pipe),
      .second_pipe (second_pipe),
      .same_pipe   (same_pipe),
      .raw         (raw)
   );

   assign first_slot  = '{1'b1, first_inst, pc_in};
   assign second_slot = '{1'b1, second_inst, pc_in + 32'd4};
   assign buffer_pipe = pipe_of(buffer.inst);

   // Slot contents default to all-zero so an unused slot never carries stale or X data.
   always_comb begin
      even_nxt   = '0;
      odd_nxt    = '0;
      buffer_nxt = buffer;
      state_nxt  = state;
      case (state)
         ST_HOLD: begin
            if (buffer_pipe == PIPE_ODD) odd_nxt = buffer;
            else                         even_nxt = buffer;
            buffer_nxt = '0;
            state_nxt  = ST_PAIR;
         end
         default: begin
            if (in_valid) begin
               if (first_pipe == PIPE_NONE) begin
                  if (second_pipe == PIPE_ODD)       odd_nxt  = second_slot;
                  else if (second_pipe == PIPE_EVEN) even_nxt = second_slot;
               end else if ((second_pipe == PIPE_NONE) || same_pipe || raw) begin
                  if (first_pipe == PIPE_ODD) odd_nxt  = first_slot;
                  else                        even_nxt = first_slot;
                  if (second_pipe != PIPE_NONE) begin
                     buffer_nxt = second_slot;
                     state_nxt  = ST_HOLD;
                  end
               end else if (first_pipe == PIPE_ODD) begin
                  odd_nxt  = first_slot;
                  even_nxt = second_slot;
               end else begin
                  even_nxt = first_slot;
                  odd_nxt  = second_slot;
               end
            end
         end
      endcase
   end

   // Flush outranks ex_stall: killed work must not be frozen in the slots.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_PAIR;
         buffer    <= '0;
         even_slot <= '0;
         odd_slot  <= '0;
      end else if (flush) begin
         state     <= ST_PAIR;
         buffer    <= '0;
         even_slot <= '0;
         odd_slot  <= '0;
      end else if (!ex_stall) begin
         state     <= state_nxt;
         buffer    <= buffer_nxt;
         even_slot <= even_nxt;
         odd_slot  <= odd_nxt;
      end
   end

   assign stall_fetch = !flush && (ex_stall || (state == ST_HOLD));

   assign even_valid = even_slot.valid;
   assign even_inst  = even_slot.inst;
   assign even_pc    = even_slot.pc;
   assign odd_valid  = odd_slot.valid;
   assign odd_inst   = odd_slot.inst;
   assign odd_pc     = odd_slot.pc;

endmodule
